alu_seq: RTL



---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/valid handshake and an iterative
// restoring divider for MOD/DIV.
//   CLK            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          launch an operation (ignored while busy)
//   OP             5-bit opcode
//   inOne, inTwo   operands A and B
//   result         registered result, held until the next valid
//   branchCompPass branch decision for BNE/BEZ, 0 for all other ops
//   carry          carry-out for adds, borrow for subtracts
//   div0           MOD/DIV issued with a zero divisor
//   valid          one-cycle pulse when result/flags update
//   busy           high while a division is in flight
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] inOne,
  input  logic [WIDTH-1:0] inTwo,
  output logic [WIDTH-1:0] result,
  output logic             branchCompPass,
  output logic             carry,
  output logic             div0,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned HALF = WIDTH / 2;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SRL  = 5'd3;
  localparam logic [4:0] OP_BREG = 5'd4;
  localparam logic [4:0] OP_SUBU = 5'd5;
  localparam logic [4:0] OP_ADDU = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_SLRA = 5'd8;
  localparam logic [4:0] OP_SEQ  = 5'd9;
  localparam logic [4:0] OP_MOD  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_BNE  = 5'd12;
  localparam logic [4:0] OP_BEZ  = 5'd13;
  localparam logic [4:0] OP_MV   = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;

  typedef enum logic {S_IDLE, S_DIVIDE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] div_q, div_q_nxt;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] div_r, div_r_nxt;     // partial remainder
  logic [WIDTH-1:0] div_d, div_d_nxt;     // latched divisor
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic             is_mod, is_mod_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             bcp_nxt, carry_nxt, div0_nxt, valid_nxt, busy_nxt;

  // Single-cycle datapath, including the divide-by-zero shortcut
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_b, alu_z;
  logic [WIDTH:0]   sum;
  logic             sh_ok;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_b   = 1'b0;
    alu_z   = 1'b0;
    sum     = {1'b0, inOne} + {1'b0, inTwo};
    sh_ok   = inTwo < WIDTH'(WIDTH);
    case (OP)
      OP_ADD, OP_ADDU, OP_ADDI: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB, OP_SUBU: begin
        alu_res = inOne - inTwo;
        alu_c   = inOne < inTwo;
      end
      OP_SLL:  alu_res = sh_ok ? (inOne << inTwo[SHW-1:0]) : '0;
      OP_SRL:  alu_res = sh_ok ? (inOne >> inTwo[SHW-1:0]) : '0;
      OP_BREG, OP_MV: alu_res = inTwo;
      OP_AND:  alu_res = inOne & inTwo;
      OP_SLRA: alu_res = WIDTH'(inOne << HALF) + inTwo;
      OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, inOne == inTwo};
      OP_BNE: begin
        alu_b   = inOne != '0;
        alu_res = alu_b ? inTwo : '0;
      end
      OP_BEZ: begin
        alu_b   = inOne == '0;
        alu_res = alu_b ? inTwo : '0;
      end
      OP_MOD: begin
        alu_res = inOne;
        alu_z   = 1'b1;
      end
      OP_DIV: begin
        alu_res = '1;
        alu_z   = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // One restoring-division step
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_new;
  logic [WIDTH-1:0] q_new;

  always_comb begin
    rem_shift = {div_r, div_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, div_d};
    qbit      = rem_shift >= {1'b0, div_d};
    rem_new   = qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    q_new     = {div_q[WIDTH-2:0], qbit};
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    div_q_nxt  = div_q;
    div_r_nxt  = div_r;
    div_d_nxt  = div_d;
    cnt_nxt    = cnt;
    is_mod_nxt = is_mod;
    result_nxt = result;
    bcp_nxt    = branchCompPass;
    carry_nxt  = carry;
    div0_nxt   = div0;
    valid_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if ((OP == OP_MOD || OP == OP_DIV) && inTwo != '0) begin
            div_q_nxt  = inOne;
            div_r_nxt  = '0;
            div_d_nxt  = inTwo;
            cnt_nxt    = SHW'(WIDTH - 1);
            is_mod_nxt = OP == OP_MOD;
            state_nxt  = S_DIVIDE;
          end else begin
            result_nxt = alu_res;
            bcp_nxt    = alu_b;
            carry_nxt  = alu_c;
            div0_nxt   = alu_z;
            valid_nxt  = 1'b1;
          end
        end
      end
      S_DIVIDE: begin
        div_q_nxt = q_new;
        div_r_nxt = rem_new;
        cnt_nxt   = cnt - SHW'(1);
        if (cnt == '0) begin
          result_nxt = is_mod ? rem_new : q_new;
          bcp_nxt    = 1'b0;
          carry_nxt  = 1'b0;
          div0_nxt   = 1'b0;
          valid_nxt  = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = state_nxt == S_DIVIDE;
  end

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      div_q          <= '0;
      div_r          <= '0;
      div_d          <= '0;
      cnt            <= '0;
      is_mod         <= 1'b0;
      result         <= '0;
      branchCompPass <= 1'b0;
      carry          <= 1'b0;
      div0           <= 1'b0;
      valid          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      div_q          <= div_q_nxt;
      div_r          <= div_r_nxt;
      div_d          <= div_d_nxt;
      cnt            <= cnt_nxt;
      is_mod         <= is_mod_nxt;
      result         <= result_nxt;
      branchCompPass <= bcp_nxt;
      carry          <= carry_nxt;
      div0           <= div0_nxt;
      valid          <= valid_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule
